// File: rtl/branch_resolve_unit.sv
// Resolves MIPS conditional branches in ID, registers the outcome for one cycle,
// and trains a table of 2-bit saturating counters read combinationally by fetch.
module branch_resolve_unit #(
  parameter int         WIDTH    = 32,
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      pc_in,
  input  logic [5:0]       opcode,
  input  logic [4:0]       rt,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             pred_in,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_link,
  output logic             res_mispredict,
  output logic [31:0]      res_pc,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  localparam int DEPTH = 2**IDX_BITS;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  logic [DEPTH-1:0][1:0] ctr_table;
  logic [IDX_BITS-1:0]   upd_idx;
  logic [IDX_BITS-1:0]   lk_idx;
  logic [1:0]            cur_ctr;
  logic [1:0]            nxt_ctr;
  logic                  is_br;
  logic                  cond;
  logic                  link;
  logic                  rs_neg;
  logic                  rs_zero;
  logic                  accept;
  logic                  mispredict;
  logic [3:0]            unused_fetch_bits;

  assign rs_neg  = rs_val[WIDTH-1];
  assign rs_zero = (rs_val == '0);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    is_br = 1'b0;
    cond  = 1'b0;
    link  = 1'b0;
    case (opcode)
      OP_BEQ:  begin is_br = 1'b1; cond = (rs_val == rt_val); end
      OP_BNE:  begin is_br = 1'b1; cond = (rs_val != rt_val); end
      OP_BGTZ: begin is_br = 1'b1; cond = !rs_neg && !rs_zero; end
      OP_BLEZ: begin is_br = 1'b1; cond = rs_neg || rs_zero; end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   begin is_br = 1'b1; cond = rs_neg; end
          RT_BGEZ:   begin is_br = 1'b1; cond = !rs_neg; end
          RT_BLTZAL: begin is_br = 1'b1; cond = rs_neg;  link = 1'b1; end
          RT_BGEZAL: begin is_br = 1'b1; cond = !rs_neg; link = 1'b1; end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  assign accept     = valid_in && is_br && !stall && !flush;
  assign mispredict = cond ^ pred_in;

  // Word-aligned PCs: drop bits [1:0], and let higher bits alias.
  assign upd_idx           = pc_in[IDX_BITS+1:2];
  assign lk_idx            = fetch_pc[IDX_BITS+1:2];
  assign unused_fetch_bits = {^fetch_pc[31:IDX_BITS+2], fetch_pc[1:0], 1'b0};

  assign cur_ctr = ctr_table[upd_idx];

  always_comb begin
    nxt_ctr = cur_ctr;
    if (cond) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'd1;
    end
  end

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  assign pred_taken = ctr_table[lk_idx][1];

  // NOTE: the counter table is explicitly reset to a known bias, unlike a plain RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_table <= {DEPTH{CNT_INIT}};
    end else if (accept) begin
      ctr_table[upd_idx] <= nxt_ctr;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_link       <= 1'b0;
      res_mispredict <= 1'b0;
      res_pc         <= 32'h0;
    end else if (flush) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_link       <= 1'b0;
      res_mispredict <= 1'b0;
    end else if (stall) begin
      res_valid      <= res_valid;
    end else if (accept) begin
      res_valid      <= 1'b1;
      res_taken      <= cond;
      res_link       <= link;
      res_mispredict <= mispredict;
      res_pc         <= pc_in;
    end else begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_link       <= 1'b0;
      res_mispredict <= 1'b0;
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= 32'h0;
      mispredict_count <= 32'h0;
    end else if (accept) begin
      if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a default 32-bit instance and a
// WIDTH=8 / IDX_BITS=2 instance for narrow signed compares and index aliasing.
module tb_branch_resolve_unit;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_LW     = 6'b100011;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] fetch_pc, pc_in, rs_val, rt_val;
  logic        valid_in, stall, flush, pred_in;
  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic        pred_taken, res_valid, res_taken, res_link, res_mispredict;
  logic [31:0] res_pc, branch_count, mispredict_count;

  logic [31:0] s_fetch_pc, s_pc_in;
  logic [7:0]  s_rs_val, s_rt_val;
  logic        s_valid_in, s_stall, s_flush, s_pred_in;
  logic [5:0]  s_opcode;
  logic [4:0]  s_rt;
  logic        s_pred_taken, s_res_valid, s_res_taken, s_res_link, s_res_mispredict;
  logic [31:0] s_res_pc, s_branch_count, s_mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mp   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .valid_in(valid_in), .stall(stall), .flush(flush), .pc_in(pc_in),
    .opcode(opcode), .rt(rt), .rs_val(rs_val), .rt_val(rt_val), .pred_in(pred_in),
    .res_valid(res_valid), .res_taken(res_taken), .res_link(res_link),
    .res_mispredict(res_mispredict), .res_pc(res_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_unit #(.WIDTH(8), .IDX_BITS(2), .CNT_INIT(2'b01)) dut_small (
    .clk(clk), .reset(reset), .fetch_pc(s_fetch_pc), .pred_taken(s_pred_taken),
    .valid_in(s_valid_in), .stall(s_stall), .flush(s_flush), .pc_in(s_pc_in),
    .opcode(s_opcode), .rt(s_rt), .rs_val(s_rs_val), .rt_val(s_rt_val), .pred_in(s_pred_in),
    .res_valid(s_res_valid), .res_taken(s_res_taken), .res_link(s_res_link),
    .res_mispredict(s_res_mispredict), .res_pc(s_res_pc),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [5:0] op, input logic [4:0] rtf, input logic [31:0] rs,
                        input logic [31:0] rtv, input logic [31:0] pc, input logic pred);
    valid_in = 1'b1;
    opcode   = op;
    rt       = rtf;
    rs_val   = rs;
    rt_val   = rtv;
    pc_in    = pc;
    pred_in  = pred;
  endtask

  task automatic set_small(input logic [5:0] op, input logic [7:0] rs, input logic [31:0] pc);
    s_valid_in = 1'b1;
    s_opcode   = op;
    s_rt       = 5'd0;
    s_rs_val   = rs;
    s_rt_val   = 8'h00;
    s_pc_in    = pc;
    s_pred_in  = 1'b0;
  endtask

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rtf;
    logic [31:0] rs;
    logic        tk;
    logic        lk;
  } vec_t;

  vec_t vecs [14] = '{
    '{OP_REGIMM, 5'b00000, 32'h8000_0000, 1'b1, 1'b0},
    '{OP_REGIMM, 5'b00000, 32'h0000_0000, 1'b0, 1'b0},
    '{OP_REGIMM, 5'b00000, 32'h0000_0001, 1'b0, 1'b0},
    '{OP_REGIMM, 5'b00001, 32'h8000_0000, 1'b0, 1'b0},
    '{OP_REGIMM, 5'b00001, 32'h0000_0000, 1'b1, 1'b0},
    '{OP_REGIMM, 5'b00001, 32'h0000_0001, 1'b1, 1'b0},
    '{OP_BGTZ,   5'b00000, 32'h8000_0000, 1'b0, 1'b0},
    '{OP_BGTZ,   5'b00000, 32'h0000_0000, 1'b0, 1'b0},
    '{OP_BGTZ,   5'b00000, 32'h0000_0001, 1'b1, 1'b0},
    '{OP_BLEZ,   5'b00000, 32'h8000_0000, 1'b1, 1'b0},
    '{OP_BLEZ,   5'b00000, 32'h0000_0000, 1'b1, 1'b0},
    '{OP_BLEZ,   5'b00000, 32'h0000_0001, 1'b0, 1'b0},
    '{OP_REGIMM, 5'b10001, 32'h0000_0000, 1'b1, 1'b1},
    '{OP_REGIMM, 5'b10000, 32'h0000_0001, 1'b0, 1'b1}
  };

  // Predictions observed at pc 0x3008 after 4 taken, 5 not-taken, 2 taken.
  logic sat_exp [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0; pred_in = 1'b0;
    opcode = 6'd0; rt = 5'd0; rs_val = '0; rt_val = '0; pc_in = '0; fetch_pc = 32'h3000;
    s_valid_in = 1'b0; s_stall = 1'b0; s_flush = 1'b0; s_pred_in = 1'b0; s_opcode = 6'd0;
    s_rt = 5'd0; s_rs_val = '0; s_rt_val = '0; s_pc_in = '0; s_fetch_pc = 32'h10;
    step(); step();
    reset = 1'b0;
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_pc", res_pc, 32'd0);
    check("rst_brcnt", branch_count, 32'd0);
    check("rst_mpcnt", mispredict_count, 32'd0);
    check("rst_pred", {31'd0, pred_taken}, 32'd0);

    // beq taken against a not-taken guess; lookup shows pre-update value.
    set_br(OP_BEQ, 5'd0, 32'h1234, 32'h1234, 32'h3000, 1'b0);
    check("beq_pred_pre", {31'd0, pred_taken}, 32'd0);
    step();
    valid_in = 1'b0;
    exp_br++; exp_mp++;
    check("beq_valid", {31'd0, res_valid}, 32'd1);
    check("beq_taken", {31'd0, res_taken}, 32'd1);
    check("beq_mis", {31'd0, res_mispredict}, 32'd1);
    check("beq_pc", res_pc, 32'h3000);
    check("beq_mpcnt", mispredict_count, 32'd1);
    check("beq_pred_post", {31'd0, pred_taken}, 32'd1);
    step();
    check("idle_valid", {31'd0, res_valid}, 32'd0);
    check("idle_taken", {31'd0, res_taken}, 32'd0);
    check("idle_pc_hold", res_pc, 32'h3000);

    // Compare classes with alternating predictions.
    for (int i = 0; i < 14; i++) begin
      set_br(vecs[i].op, vecs[i].rtf, vecs[i].rs, 32'h0, 32'h3004, 1'(i % 2));
      step();
      exp_br++;
      if (vecs[i].tk != 1'(i % 2)) exp_mp++;
      check($sformatf("cmp%0d_valid", i), {31'd0, res_valid}, 32'd1);
      check($sformatf("cmp%0d_taken", i), {31'd0, res_taken}, {31'd0, vecs[i].tk});
      check($sformatf("cmp%0d_link", i), {31'd0, res_link}, {31'd0, vecs[i].lk});
      check($sformatf("cmp%0d_mis", i), {31'd0, res_mispredict},
            {31'd0, vecs[i].tk ^ 1'(i % 2)});
    end
    valid_in = 1'b0;
    check("cmp_brcnt", branch_count, 32'(exp_br));
    check("cmp_mpcnt", mispredict_count, 32'(exp_mp));

    // Non-branches: no result, no training, no stats.
    set_br(OP_REGIMM, 5'b00010, 32'h8000_0000, 32'h0, 32'h3000, 1'b1);
    step();
    check("regimm_bad_valid", {31'd0, res_valid}, 32'd0);
    set_br(OP_LW, 5'd0, 32'h8000_0000, 32'h0, 32'h3000, 1'b1);
    step();
    valid_in = 1'b0;
    check("lw_valid", {31'd0, res_valid}, 32'd0);
    check("nonbr_brcnt", branch_count, 32'(exp_br));
    check("nonbr_mpcnt", mispredict_count, 32'(exp_mp));
    check("nonbr_pred", {31'd0, pred_taken}, 32'd1);

    // Saturation at pc 0x3008, guess always taken.
    fetch_pc = 32'h3008;
    for (int i = 0; i < 11; i++) begin
      if (i < 4 || i > 8) set_br(OP_BNE, 5'd0, 32'd1, 32'd2, 32'h3008, 1'b1);
      else begin
        set_br(OP_BEQ, 5'd0, 32'd1, 32'd2, 32'h3008, 1'b1);
        exp_mp++;
      end
      exp_br++;
      step();
      check($sformatf("sat%0d_pred", i), {31'd0, pred_taken}, {31'd0, sat_exp[i]});
    end
    valid_in = 1'b0;
    check("sat_brcnt", branch_count, 32'(exp_br));
    check("sat_mpcnt", mispredict_count, 32'(exp_mp));

    // Stall holds results; a pending taken branch at 0x3010 must not train.
    set_br(OP_BNE, 5'd0, 32'd1, 32'd2, 32'h300C, 1'b0);
    step();
    exp_br++; exp_mp++;
    fetch_pc = 32'h3010;
    set_br(OP_BNE, 5'd0, 32'd1, 32'd2, 32'h3010, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_valid", i), {31'd0, res_valid}, 32'd1);
      check($sformatf("stall%0d_mis", i), {31'd0, res_mispredict}, 32'd1);
      check($sformatf("stall%0d_pc", i), res_pc, 32'h300C);
      check($sformatf("stall%0d_brcnt", i), branch_count, 32'(exp_br));
      check($sformatf("stall%0d_pred", i), {31'd0, pred_taken}, 32'd0);
    end
    flush = 1'b1;
    step();
    check("flush_valid", {31'd0, res_valid}, 32'd0);
    check("flush_taken", {31'd0, res_taken}, 32'd0);
    check("flush_mis", {31'd0, res_mispredict}, 32'd0);
    check("flush_pc", res_pc, 32'h300C);
    check("flush_brcnt", branch_count, 32'(exp_br));
    check("flush_mpcnt", mispredict_count, 32'(exp_mp));
    check("flush_pred", {31'd0, pred_taken}, 32'd0);
    flush = 1'b0;
    stall = 1'b0;

    // Reset while stalled with a live result.
    set_br(OP_BGEZAL_dummy(), 5'b10001, 32'd0, 32'd0, 32'h3014, 1'b0);
    step();
    check("pre_rst_link", {31'd0, res_link}, 32'd1);
    stall = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;
    valid_in = 1'b0;
    check("mrst_valid", {31'd0, res_valid}, 32'd0);
    check("mrst_taken", {31'd0, res_taken}, 32'd0);
    check("mrst_link", {31'd0, res_link}, 32'd0);
    check("mrst_mis", {31'd0, res_mispredict}, 32'd0);
    check("mrst_pc", res_pc, 32'd0);
    check("mrst_brcnt", branch_count, 32'd0);
    check("mrst_mpcnt", mispredict_count, 32'd0);
    fetch_pc = 32'h3000;
    #1;
    check("mrst_pred_3000", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'h3008;
    #1;
    check("mrst_pred_3008", {31'd0, pred_taken}, 32'd0);

    // Narrow instance: 8'h80 is negative; pcs 0x0, 0x10, 0x20 share index 0.
    set_small(OP_BLEZ, 8'h80, 32'h0);
    step();
    check("s_blez_valid", {31'd0, s_res_valid}, 32'd1);
    check("s_blez_taken", {31'd0, s_res_taken}, 32'd1);
    check("s_alias_pred1", {31'd0, s_pred_taken}, 32'd1);
    set_small(OP_BGTZ, 8'h80, 32'h10);
    step();
    check("s_bgtz_neg", {31'd0, s_res_taken}, 32'd0);
    check("s_alias_pred0", {31'd0, s_pred_taken}, 32'd0);
    set_small(OP_BGTZ, 8'h7F, 32'h20);
    step();
    s_valid_in = 1'b0;
    check("s_bgtz_pos", {31'd0, s_res_taken}, 32'd1);
    check("s_alias_pred2", {31'd0, s_pred_taken}, 32'd1);
    check("s_brcnt", s_branch_count, 32'd3);
    check("s_mpcnt", s_mispredict_count, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [5:0] OP_BGEZAL_dummy();
    return OP_REGIMM;
  endfunction

endmodule
